bit_serializer: RTL and testbench



---
 rtl/serial_pkg.sv | 18 +
 rtl/bit_serializer.sv | 105 ++++++++++
 tb/tb_bit_serializer.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/serial_pkg.sv
// Shared definitions for the bit serializer: FSM state encoding and the
// length clamp used when a parallel word is accepted.
package serial_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  // A length of zero, or one longer than the word, means "send the whole word".
  function automatic int unsigned clamp_len(input int unsigned len, input int unsigned width);
    if ((len == 32'd0) || (len > width)) begin
      return width;
    end else begin
      return len;
    end
  endfunction

endpackage

// File: rtl/bit_serializer.sv
// Parallel-to-serial converter with a valid/ready input, a bit-rate enable and
// an optional forced-zero idle gap between frames.
module bit_serializer
  import serial_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int MSB_FIRST  = 1,
  parameter int GAP_CYCLES = 2,
  parameter int LEN_W      = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_en,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [LEN_W-1:0] in_len,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             ser_last,
  output logic             busy,
  output logic [7:0]       frame_count
);

  localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

  logic [1:0]       state_r;
  logic [WIDTH-1:0] shreg_r;
  logic [LEN_W-1:0] cnt_r;
  logic [GAP_W-1:0] gap_r;
  logic [7:0]       frame_count_r;
  logic             head_bit_s;

  // Bit currently at the output end of the shift register.
  always_comb begin
    head_bit_s = 1'b0;
    if (MSB_FIRST != 0) begin
      head_bit_s = shreg_r[WIDTH-1];
    end else begin
      head_bit_s = shreg_r[0];
    end
  end

  // Outputs decode registered state only, so nothing on in_* reaches ser_*.
  always_comb begin
    in_ready    = (state_r == ST_IDLE);
    busy        = (state_r != ST_IDLE);
    ser_valid   = (state_r == ST_SHIFT);
    ser_last    = (state_r == ST_SHIFT) && (cnt_r == LEN_W'(1));
    ser_out     = (state_r == ST_SHIFT) ? head_bit_s : 1'b0;
    frame_count = frame_count_r;
  end

  // Frame FSM: accept, shift one bit per enabled tick, then optional idle gap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      shreg_r       <= '0;
      cnt_r         <= '0;
      gap_r         <= '0;
      frame_count_r <= 8'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (in_valid) begin
            shreg_r <= in_data;
            cnt_r   <= LEN_W'(clamp_len(32'(in_len), 32'(WIDTH)));
            state_r <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (bit_en) begin
            if (MSB_FIRST != 0) begin
              shreg_r <= {shreg_r[WIDTH-2:0], 1'b0};
            end else begin
              shreg_r <= {1'b0, shreg_r[WIDTH-1:1]};
            end
            cnt_r <= cnt_r - LEN_W'(1);
            if (cnt_r == LEN_W'(1)) begin
              frame_count_r <= frame_count_r + 8'd1;
              if (GAP_CYCLES > 0) begin
                gap_r   <= GAP_W'(GAP_CYCLES);
                state_r <= ST_GAP;
              end else begin
                state_r <= ST_IDLE;
              end
            end
          end
        end
        ST_GAP: begin
          if (bit_en) begin
            gap_r <= gap_r - GAP_W'(1);
            if (gap_r == GAP_W'(1)) begin
              state_r <= ST_IDLE;
            end
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bit_serializer.sv
// Directed self-checking bench: three serializer instances cover MSB-first with
// gap, LSB-first with gap, and gapless back-to-back 2-bit frames for the wrap.
module tb_bit_serializer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic bit_en = 1'b1;
  int   errors = 0;
  int   checks = 0;

  logic       v0 = 1'b0, v1 = 1'b0, v2 = 1'b0;
  logic [7:0] d0 = 8'd0, d1 = 8'd0, d2 = 8'd0;
  logic [3:0] l0 = 4'd0, l1 = 4'd0, l2 = 4'd0;
  logic       r0, r1, r2, so0, so1, so2, sv0, sv1, sv2, sl0, sl1, sl2, b0, b1, b2;
  logic [7:0] fc0, fc1, fc2;

  always #5 clk = ~clk;

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1), .GAP_CYCLES(2)) u0 (
    .clk(clk), .rst(rst), .bit_en(bit_en), .in_valid(v0), .in_ready(r0),
    .in_data(d0), .in_len(l0), .ser_out(so0), .ser_valid(sv0), .ser_last(sl0),
    .busy(b0), .frame_count(fc0));

  bit_serializer #(.WIDTH(8), .MSB_FIRST(0), .GAP_CYCLES(2)) u1 (
    .clk(clk), .rst(rst), .bit_en(bit_en), .in_valid(v1), .in_ready(r1),
    .in_data(d1), .in_len(l1), .ser_out(so1), .ser_valid(sv1), .ser_last(sl1),
    .busy(b1), .frame_count(fc1));

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1), .GAP_CYCLES(0)) u2 (
    .clk(clk), .rst(rst), .bit_en(bit_en), .in_valid(v2), .in_ready(r2),
    .in_data(d2), .in_len(l2), .ser_out(so2), .ser_valid(sv2), .ser_last(sl2),
    .busy(b2), .frame_count(fc2));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer a word to u0 for exactly one (accepting) edge.
  task automatic offer0(input logic [7:0] data, input logic [3:0] len);
    v0 = 1'b1; d0 = data; l0 = len;
    step();
    v0 = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({r0, sv0, so0, sl0, b0} !== 5'b10000 || fc0 !== 8'd0 ||
        {r1, sv1, r2, sv2} !== 4'b1010) begin
      errors++;
      $display("FAIL reset_state: got ready/valid/out/last/busy=%b%b%b%b%b fc=%0d, want 10000 fc=0",
               r0, sv0, so0, sl0, b0, fc0);
    end
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_full_frame();
    logic [7:0] exp_bits = 8'b1011_0010;
    bit_en = 1'b1;
    offer0(8'b1011_0010, 4'd0);
    for (int n = 0; n < 11; n++) begin
      @(negedge clk);
      checks++;
      if (n < 8) begin
        if (so0 !== exp_bits[7-n] || sv0 !== 1'b1 || sl0 !== (n == 7) || r0 !== 1'b0) begin
          errors++;
          $display("FAIL full_bit%0d: got out=%b valid=%b last=%b ready=%b, want out=%b valid=1 last=%b ready=0",
                   n, so0, sv0, sl0, r0, exp_bits[7-n], (n == 7));
        end
      end else begin
        if (so0 !== 1'b0 || sv0 !== 1'b0 || r0 !== (n == 10) || fc0 !== 8'd1) begin
          errors++;
          $display("FAIL full_gap%0d: got out=%b valid=%b ready=%b fc=%0d, want out=0 valid=0 ready=%b fc=1",
                   n, so0, sv0, r0, fc0, (n == 10));
        end
      end
      step();
    end
  endtask

  task automatic test_reset_mid();
    offer0(8'hFF, 4'd0);
    step();
    step();
    rst = 1'b1;
    #1;
    checks++;
    if ({r0, sv0, so0, b0} !== 4'b1000 || fc0 !== 8'd0) begin
      errors++;
      $display("FAIL reset_mid: got ready/valid/out/busy=%b%b%b%b fc=%0d, want 1000 fc=0",
               r0, sv0, so0, b0, fc0);
    end
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_short_lsb();
    v1 = 1'b1; d1 = 8'h0D; l1 = 4'd3;
    step();
    v1 = 1'b0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      checks++;
      if (n < 3) begin
        if (so1 !== ((n == 1) ? 1'b0 : 1'b1) || sv1 !== 1'b1 || sl1 !== (n == 2)) begin
          errors++;
          $display("FAIL short_bit%0d: got out=%b valid=%b last=%b, want out=%b valid=1 last=%b",
                   n, so1, sv1, sl1, (n != 1), (n == 2));
        end
      end else begin
        if (so1 !== 1'b0 || sv1 !== 1'b0 || r1 !== (n == 5)) begin
          errors++;
          $display("FAIL short_gap%0d: got out=%b valid=%b ready=%b, want out=0 valid=0 ready=%b",
                   n, so1, sv1, r1, (n == 5));
        end
      end
      step();
    end
  endtask

  task automatic test_throttled();
    logic [7:0] exp_bits = 8'hA5;
    bit_en = 1'b0;
    offer0(8'hA5, 4'd8);
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      checks++;
      if (so0 !== exp_bits[7 - c/3] || sv0 !== 1'b1) begin
        errors++;
        $display("FAIL throttle_c%0d: got out=%b valid=%b, want out=%b valid=1",
                 c, so0, sv0, exp_bits[7 - c/3]);
      end
      bit_en = ((c % 3) == 2);
      step();
    end
    @(negedge clk);
    checks++;
    if (sv0 !== 1'b0 || fc0 !== 8'd1) begin
      errors++;
      $display("FAIL throttle_end: got valid=%b fc=%0d, want valid=0 fc=1", sv0, fc0);
    end
    bit_en = 1'b1;
    step();
    step();
  endtask

  task automatic test_busy_drop();
    bit_en = 1'b1;
    offer0(8'h00, 4'd0);
    v0 = 1'b1; d0 = 8'hFF; l0 = 4'd0;
    for (int n = 0; n < 11; n++) begin
      @(negedge clk);
      checks++;
      if (so0 !== 1'b0 || r0 !== (n == 10)) begin
        errors++;
        $display("FAIL busy_drop%0d: got out=%b ready=%b, want out=0 ready=%b", n, so0, r0, (n == 10));
      end
      step();
    end
    v0 = 1'b0;
    @(negedge clk);
    checks++;
    if (so0 !== 1'b1 || sv0 !== 1'b1 || fc0 !== 8'd2) begin
      errors++;
      $display("FAIL busy_start: got out=%b valid=%b fc=%0d, want out=1 valid=1 fc=2", so0, sv0, fc0);
    end
    for (int n = 0; n < 12; n++) step();
    @(negedge clk);
    checks++;
    if (r0 !== 1'b1 || fc0 !== 8'd3) begin
      errors++;
      $display("FAIL busy_end: got ready=%b fc=%0d, want ready=1 fc=3", r0, fc0);
    end
  endtask

  task automatic test_back_to_back_wrap();
    logic [7:0] exp_fc = 8'd0;
    int frames = 0;
    logic prev_last = 1'b0;
    bit_en = 1'b1;
    v2 = 1'b1; d2 = 8'b1000_0000; l2 = 4'd2;
    for (int c = 0; c < 1200 && frames < 256; c++) begin
      @(negedge clk);
      if (prev_last) begin
        checks++;
        if (r2 !== 1'b1 || sv2 !== 1'b0 || fc2 !== exp_fc) begin
          errors++;
          $display("FAIL wrap_frame%0d: got ready=%b valid=%b fc=%0d, want ready=1 valid=0 fc=%0d",
                   frames, r2, sv2, fc2, exp_fc);
        end
      end
      prev_last = sl2;
      if (sl2) begin
        frames++;
        exp_fc = exp_fc + 8'd1;
        if (frames == 256) v2 = 1'b0;
      end
      step();
    end
    step();
    @(negedge clk);
    checks++;
    if (frames !== 256 || fc2 !== 8'd0 || r2 !== 1'b1) begin
      errors++;
      $display("FAIL wrap_total: got frames=%0d fc=%0d ready=%b, want frames=256 fc=0 ready=1",
               frames, fc2, r2);
    end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_reset_mid();
    test_short_lsb();
    test_throttled();
    test_busy_drop();
    test_back_to_back_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
